// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//
// Central stall/flush scheduler for the 5-stage pipeline. Every cycle it
// decides, from the current state and the hazard inputs, which pipeline
// registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) load, hold, or take a bubble.
//
// Priority of the decision, highest first:
//   1. HALT state         - everything frozen, MEM/WB takes bubbles
//   2. memory stall       - dmem_req && !dmem_ready
//   3. EX redirect        - squash IF/ID and ID/EX, PC loads the target
//   4. load-use hazard    - hold PC and IF/ID, bubble into ID/EX
//
// Parameters:
//   MEM_TIMEOUT  consecutive memory-wait cycles tolerated before halting (1..65535)
//   CNT_W        width of the performance counters
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ID_rs1, ID_rs2                source registers of the instruction in ID
//   ID_uses_rs1, ID_uses_rs2      the ID instruction really reads that source
//   EX_rd, EX_MemRead             destination / is-load of the instruction in EX
//   EX_redirect                   taken branch or jump resolved in EX
//   dmem_req, dmem_ready          MEM-stage access issued / completed this cycle
//   pc_en, ifid_en, idex_en,
//   exmem_en                      stage register load enables
//   ifid_flush, idex_flush,
//   memwb_flush                   bubble insertion
//   halted                        core halted after a memory timeout
//   stall_cnt, flush_cnt          performance counters
//
// Optional feature macro:
//   HAZ_PERF_CNT_EN  when defined, stall_cnt counts cycles with pc_en low and
//                    flush_cnt counts cycles with an IF/ID or ID/EX flush; both
//                    saturate at all-ones. When undefined both read 0 and no
//                    counter flops exist.

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  // Last wait-count value that may still be followed by another wait cycle.
  localparam logic [15:0] WCNT_LAST = 16'(MEM_TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] wcnt;
  logic [15:0] wcnt_nxt;

  logic mem_stall;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign mem_stall = dmem_req && !dmem_ready;

  // x0 is never a real producer, so a load into x0 cannot create a hazard.
  assign rs1_hit  = ID_uses_rs1 && (ID_rs1 == EX_rd);
  assign rs2_hit  = ID_uses_rs2 && (ID_rs2 == EX_rd);
  assign load_use = EX_MemRead && (EX_rd != 5'd0) && (rs1_hit || rs2_hit);

  // Combinational decision. The RUN/MEM_WAIT distinction only matters for the
  // timeout: a cycle in MEM_WAIT whose access completes (or whose request is
  // withdrawn) decodes exactly like RUN, so a pending redirect or load-use
  // acts in that same cycle.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    state_nxt   = state;
    wcnt_nxt    = wcnt;

    if (state == HALT) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      wcnt_nxt    = wcnt + 16'd1;
      // >= rather than == keeps MEM_TIMEOUT=1 from wrapping the counter.
      if ((state == MEM_WAIT) && (wcnt >= WCNT_LAST)) begin
        state_nxt = HALT;
      end else begin
        state_nxt = MEM_WAIT;
      end
    end else begin
      state_nxt = RUN;
      wcnt_nxt  = 16'd0;
      if (EX_redirect) begin
        // The ID instruction is wrong-path, so any load-use on it is moot.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        // One bubble suffices: the load moves on to MEM next cycle.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= 16'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  assign halted = (state == HALT);

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating counters; they only clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if ((ifid_flush || idex_flush) && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4). The driver
// issues one input vector per cycle and queues the hand-computed response;
// a monitor pops and compares on every falling edge.

module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] ID_rs1;
  logic [4:0] ID_rs2;
  logic       ID_uses_rs1;
  logic       ID_uses_rs2;
  logic [4:0] EX_rd;
  logic       EX_MemRead;
  logic       EX_redirect;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       memwb_flush;
  logic       halted;
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ID_rs1     (ID_rs1),
    .ID_rs2     (ID_rs2),
    .ID_uses_rs1(ID_uses_rs1),
    .ID_uses_rs2(ID_uses_rs2),
    .EX_rd      (EX_rd),
    .EX_MemRead (EX_MemRead),
    .EX_redirect(EX_redirect),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .idex_en    (idex_en),
    .exmem_en   (exmem_en),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .memwb_flush(memwb_flush),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  // Output vector layout:
  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, halted}
  localparam logic [7:0] NORMAL  = 8'b1111_000_0;
  localparam logic [7:0] LOADUSE = 8'b0011_010_0;
  localparam logic [7:0] REDIR   = 8'b1111_110_0;
  localparam logic [7:0] MSTALL  = 8'b0000_001_0;
  localparam logic [7:0] HALTV   = 8'b0000_001_1;

  typedef struct {
    string      name;
    logic [7:0] outs;
    logic [3:0] scnt;
    logic [3:0] fcnt;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  logic [3:0] model_stall = 4'd0;
  logic [3:0] model_flush = 4'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input string name, input logic rst_v,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] exrd, input logic memread,
                               input logic redirect, input logic req,
                               input logic ready, input logic [7:0] exp_outs);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = rst_v;
    ID_rs1      = rs1;
    ID_uses_rs1 = u1;
    ID_rs2      = rs2;
    ID_uses_rs2 = u2;
    EX_rd       = exrd;
    EX_MemRead  = memread;
    EX_redirect = redirect;
    dmem_req    = req;
    dmem_ready  = ready;
    if (rst_v) begin
      model_stall = 4'd0;
      model_flush = 4'd0;
    end
    e.name = name;
    e.outs = exp_outs;
`ifdef HAZ_PERF_CNT_EN
    e.scnt = model_stall;
    e.fcnt = model_flush;
`else
    e.scnt = 4'd0;
    e.fcnt = 4'd0;
`endif
    sb.push_back(e);
    if (!rst_v) begin
      if (!exp_outs[7] && (model_stall != 4'hF)) model_stall = model_stall + 4'd1;
      if ((exp_outs[3] || exp_outs[2]) && (model_flush != 4'hF)) model_flush = model_flush + 4'd1;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, halted};
    checks++;
    if ((act !== e.outs) || (stall_cnt !== e.scnt) || (flush_cnt !== e.fcnt)) begin
      failures++;
      $display("[TB] FAIL %s: got out=%b stall_cnt=%0d flush_cnt=%0d, want out=%b stall_cnt=%0d flush_cnt=%0d",
               e.name, act, stall_cnt, flush_cnt, e.outs, e.scnt, e.fcnt);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
    EX_rd = 5'd0; EX_MemRead = 1'b0; EX_redirect = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;

    //             name            rst rs1  u1  rs2  u2  exrd memrd redir req rdy  expect
    applyStimulus("reset",          1, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    0,  0,  NORMAL);
    applyStimulus("reset_loaduse",  1, 5'd5, 1, 5'd1, 1, 5'd5, 1,   0,    0,  0,  LOADUSE);
    applyStimulus("idle",           0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    0,  0,  NORMAL);
    applyStimulus("lu_rs1",         0, 5'd5, 1, 5'd1, 1, 5'd5, 1,   0,    0,  0,  LOADUSE);
    applyStimulus("lu_after",       0, 5'd5, 1, 5'd1, 1, 5'd0, 0,   0,    0,  0,  NORMAL);
    applyStimulus("lu_rd0",         0, 5'd0, 1, 5'd0, 1, 5'd0, 1,   0,    0,  0,  NORMAL);
    applyStimulus("lu_rs2",         0, 5'd3, 1, 5'd7, 1, 5'd7, 1,   0,    0,  0,  LOADUSE);
    applyStimulus("lu_rs2_unused",  0, 5'd3, 1, 5'd7, 0, 5'd7, 1,   0,    0,  0,  NORMAL);
    applyStimulus("lu_rs1_unused",  0, 5'd9, 0, 5'd3, 1, 5'd9, 1,   0,    0,  0,  NORMAL);
    applyStimulus("match_noload",   0, 5'd5, 1, 5'd1, 1, 5'd5, 0,   0,    0,  0,  NORMAL);
    applyStimulus("redir_lu",       0, 5'd5, 1, 5'd1, 1, 5'd5, 1,   1,    0,  0,  REDIR);
    applyStimulus("redir",          0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   1,    0,  0,  REDIR);
    applyStimulus("ready_no_stall", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  1,  NORMAL);
    applyStimulus("mwait_1",        0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("mwait_2",        0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("mwait_3",        0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("mwait_done",     0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  1,  NORMAL);
    applyStimulus("mwait_idle",     0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    0,  0,  NORMAL);
    applyStimulus("rw_wait_1",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   1,    1,  0,  MSTALL);
    applyStimulus("rw_wait_2",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   1,    1,  0,  MSTALL);
    applyStimulus("rw_ready",       0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   1,    1,  1,  REDIR);
    applyStimulus("wd_wait",        0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("wd_lu",          0, 5'd4, 1, 5'd0, 0, 5'd4, 1,   0,    0,  0,  LOADUSE);
    applyStimulus("near_to_1",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("near_to_2",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("near_to_3",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("near_to_done",   0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  1,  NORMAL);
    applyStimulus("to_wait_1",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("to_wait_2",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("to_wait_3",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("to_wait_4",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  MSTALL);
    applyStimulus("halt_5",         0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  0,  HALTV);
    applyStimulus("halt_ready",     0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    1,  1,  HALTV);
    applyStimulus("halt_redir",     0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   1,    0,  0,  HALTV);
    applyStimulus("halt_lu",        0, 5'd5, 1, 5'd1, 1, 5'd5, 1,   0,    0,  0,  HALTV);
    applyStimulus("halt_idle",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    0,  0,  HALTV);
    applyStimulus("halt_rst",       1, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    0,  0,  NORMAL);
    applyStimulus("post_rst",       0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    0,  0,  NORMAL);
    applyStimulus("post_rst_redir", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   1,    0,  0,  REDIR);
    applyStimulus("post_rst_idle",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0,    0,  0,  NORMAL);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
